param_subtractor_reg: RTL and testbench

- Parameterized unsigned subtractor: diff = a − b modulo 2^WIDTH; borrow flags a < b.
- Result is registered on one clock with a valid flag, so it can drop into datapath pipelines as a single-cycle arithmetic stage.
- Internally built from a borrow-ripple chain of fixed-width slices.

---
 rtl/param_subtractor_reg_pkg.sv | 17 +
 rtl/param_subtractor_reg_sub_slice.sv | 19 +
 rtl/param_subtractor_reg.sv | 70 +++++++
 tb/tb_param_subtractor_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/param_subtractor_reg_pkg.sv
// Shared helpers for the registered ripple-borrow subtractor.
package param_subtractor_reg_pkg;

    // Number of slices needed to cover `width` bits with `slice_w`-bit slices.
    // The top slice is narrower when slice_w does not divide width.
    function automatic int slice_count(input int width, input int slice_w);
        return (width + slice_w - 1) / slice_w;
    endfunction

    // Width of slice `k`. Every slice is slice_w bits except possibly the top one.
    function automatic int slice_width(input int width, input int slice_w, input int k);
        int lo;
        lo = k * slice_w;
        return ((width - lo) < slice_w) ? (width - lo) : slice_w;
    endfunction

endpackage

// File: rtl/param_subtractor_reg_sub_slice.sv
// One W-bit slice of the borrow-ripple subtract chain: d = x - y - bin.
module sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    // One extra bit catches the borrow: it is set exactly when x < y + bin.
    logic [W:0] w_full;

    assign w_full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    assign d      = w_full[W-1:0];
    assign bout   = w_full[W];

endmodule

// File: rtl/param_subtractor_reg.sv
// Registered unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
// The subtract is a combinational ripple of sub_slice instances feeding one
// output register stage, so latency is exactly one clock.
module param_subtractor_reg
    import param_subtractor_reg_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int N_SLICES = slice_count(WIDTH, SLICE_W);

    // w_borrow[k] is the borrow into slice k; w_borrow[N_SLICES] leaves the top.
    logic [N_SLICES:0] w_borrow;
    logic [WIDTH-1:0]  w_diff;

    logic              r_valid;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;

    assign w_borrow[0] = 1'b0;

    for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
        localparam int LO = k * SLICE_W;
        localparam int SW = slice_width(WIDTH, SLICE_W, k);

        sub_slice #(
            .W (SW)
        ) u_slice (
            .x    (a[LO +: SW]),
            .y    (b[LO +: SW]),
            .bin  (w_borrow[k]),
            .d    (w_diff[LO +: SW]),
            .bout (w_borrow[k+1])
        );
    end

    // Output stage: capture a fresh result on in_valid, otherwise hold it and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // so ordering between statements here never changes behaviour.
            r_valid  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_valid <= in_valid;
            // NOTE: a missing else inside always_ff means "hold" and builds an
            // enable flop; the same omission in always_comb would infer a latch.
            if (in_valid) begin
                r_diff   <= w_diff;
                r_borrow <= w_borrow[N_SLICES];
            end
        end
    end

    assign out_valid = r_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_param_subtractor_reg.sv
// Self-checking bench for param_subtractor_reg: directed vector table on the
// 8-bit instance, hand-written reset and slice-boundary sequences, and a
// random stream over WIDTH = 1, 8, 10, 16 instances checked against a model.
module tb_param_subtractor_reg;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;

    logic [7:0]  a8,  b8,  d8;
    logic [9:0]  a10, b10, d10;
    logic [0:0]  a1,  b1,  d1;
    logic [15:0] a16, b16, d16;
    logic        v8, v10, v1, v16;
    logic        br8, br10, br1, br16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_subtractor_reg #(.WIDTH(8), .SLICE_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
        .out_valid(v8), .diff(d8), .borrow(br8)
    );
    param_subtractor_reg #(.WIDTH(10), .SLICE_W(4)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a10), .b(b10),
        .out_valid(v10), .diff(d10), .borrow(br10)
    );
    param_subtractor_reg #(.WIDTH(1), .SLICE_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
        .out_valid(v1), .diff(d1), .borrow(br1)
    );
    param_subtractor_reg #(.WIDTH(16), .SLICE_W(5)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a16), .b(b16),
        .out_valid(v16), .diff(d16), .borrow(br16)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [10];

    // Random-phase reference state, one per instance.
    logic [7:0]  m_d8;  logic m_b8;
    logic [9:0]  m_d10; logic m_b10;
    logic [0:0]  m_d1;  logic m_b1;
    logic [15:0] m_d16; logic m_b16;
    logic        m_v;

    initial begin
        vecs[0] = '{1'b1, 8'd200, 8'd55,  8'd145, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h5A,  8'h5A,  8'h00,  1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'd3,   8'd5,   8'hFE,  1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00,  8'hFF,  8'h01,  1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h10,  8'h01,  8'h0F,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'd9,   8'd4,   8'd5,   1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'd1,   8'd2,   8'd5,   1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00,  8'hFF,  8'd5,   1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h00,  8'h01,  8'hFF,  1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h77,  8'h01,  8'hFF,  1'b1, 1'b0};

        a10 = '0; b10 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;

        // Reset wins over a valid input.
        rst = 1'b1; in_valid = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        tick();
        check("reset_diff",   32'(d8),  32'h00);
        check("reset_borrow", 32'(br8), 32'h0);
        check("reset_valid",  32'(v8),  32'h0);
        check("reset_valid16", 32'(v16), 32'h0);

        // First result after release.
        rst = 1'b0;
        tick();
        check("post_reset_diff",   32'(d8),  32'hFE);
        check("post_reset_borrow", 32'(br8), 32'h0);
        check("post_reset_valid",  32'(v8),  32'h1);

        // Directed table on the 8-bit instance, including valid gating.
        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].vld;
            a8 = vecs[i].a;
            b8 = vecs[i].b;
            tick();
            check($sformatf("vec%0d_diff", i),   32'(d8),  32'(vecs[i].exp_diff));
            check($sformatf("vec%0d_borrow", i), 32'(br8), 32'(vecs[i].exp_borrow));
            check($sformatf("vec%0d_valid", i),  32'(v8),  32'(vecs[i].exp_valid));
        end

        // Mid-run reset clears a non-zero held result even with in_valid high.
        rst = 1'b1; in_valid = 1'b1; a8 = 8'd1; b8 = 8'd2;
        tick();
        check("midreset_diff",   32'(d8),  32'h00);
        check("midreset_borrow", 32'(br8), 32'h0);
        check("midreset_valid",  32'(v8),  32'h0);
        rst = 1'b0;

        // Borrow rippling through several slices on the wider instances.
        a10 = 10'h200; b10 = 10'h001;
        a16 = 16'h8000; b16 = 16'h0001;
        a1  = 1'b0;    b1  = 1'b1;
        tick();
        check("w10_ripple_diff",   32'(d10),  32'h1FF);
        check("w10_ripple_borrow", 32'(br10), 32'h0);
        check("w16_ripple_diff",   32'(d16),  32'h7FFF);
        check("w16_ripple_borrow", 32'(br16), 32'h0);
        check("w1_diff",           32'(d1),   32'h1);
        check("w1_borrow",         32'(br1),  32'h1);
        a10 = 10'h000; b10 = 10'h3FF;
        a16 = 16'h0000; b16 = 16'hFFFF;
        a1  = 1'b1;     b1  = 1'b1;
        tick();
        check("w10_wrap_diff",   32'(d10),  32'h001);
        check("w10_wrap_borrow", 32'(br10), 32'h1);
        check("w16_wrap_diff",   32'(d16),  32'h0001);
        check("w16_wrap_borrow", 32'(br16), 32'h1);
        check("w1_eq_diff",      32'(d1),   32'h0);
        check("w1_eq_borrow",    32'(br1),  32'h0);

        // Random stream, mostly valid, checked against the registered model.
        m_d8 = d8; m_b8 = br8; m_d10 = d10; m_b10 = br10;
        m_d1 = d1; m_b1 = br1; m_d16 = d16; m_b16 = br16;
        for (int i = 0; i < 10000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a8  = 8'($urandom);  b8  = 8'($urandom);
            a10 = 10'($urandom); b10 = 10'($urandom);
            a1  = 1'($urandom);  b1  = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            m_v = in_valid;
            if (in_valid) begin
                m_d8  = 8'((int'(a8)  - int'(b8))  & 32'hFF);   m_b8  = (a8  < b8);
                m_d10 = 10'((int'(a10) - int'(b10)) & 32'h3FF); m_b10 = (a10 < b10);
                m_d1  = 1'((int'(a1)  - int'(b1))  & 32'h1);    m_b1  = (a1  < b1);
                m_d16 = 16'((int'(a16) - int'(b16)) & 32'hFFFF); m_b16 = (a16 < b16);
            end
            tick();
            check("rnd_w8",  {22'd0, v8,  br8,  d8},  {22'd0, m_v, m_b8,  m_d8});
            check("rnd_w10", {20'd0, v10, br10, d10}, {20'd0, m_v, m_b10, m_d10});
            check("rnd_w1",  {29'd0, v1,  br1,  d1},  {29'd0, m_v, m_b1,  m_d1});
            check("rnd_w16", {14'd0, v16, br16, d16}, {14'd0, m_v, m_b16, m_d16});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
